// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------
// if_fetch_if
// Bundle of every signal of the instruction-fetch stage other than clk/rst.
//   master : the fetch stage (drives imem_req/imem_addr and the IF/ID triple)
//   slave  : the surroundings (instruction memory, ID redirect, IF/ID stall)
// Signals:
//   stall            IF/ID cannot capture this cycle
//   br_flag/target   redirect request from ID (single-cycle pulse)
//   imem_req/addr    fetch request and word address to instruction memory
//   imem_ack/rdata   memory accepted the request; instruction word this cycle
//   if_pc/inst/valid registered instruction delivered to IF/ID
//   if_adel          misaligned fetch flag (only with FETCH_ALIGN_CHECK_EN)
// ---------------------------------------------------------------------------
interface if_fetch_if;
  logic        stall;
  logic        br_flag;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        if_adel;
`endif

  modport master (
    input  stall, br_flag, br_target, imem_ack, imem_rdata,
`ifdef FETCH_ALIGN_CHECK_EN
    output if_adel,
`endif
    output imem_req, imem_addr, if_pc, if_inst, if_valid
  );

  modport slave (
    output stall, br_flag, br_target, imem_ack, imem_rdata,
`ifdef FETCH_ALIGN_CHECK_EN
    input  if_adel,
`endif
    input  imem_req, imem_addr, if_pc, if_inst, if_valid
  );
endinterface

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage of flowCPU_mips. Owns the PC, issues word fetches
// over a variable-latency req/ack handshake, delivers one registered
// (pc, inst, valid) triple per cycle to IF/ID, absorbs a stall with a
// one-entry hold buffer and applies branch/jump redirects from ID.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   if_fetch_if.master (memory handshake, redirect, IF/ID outputs)
// Parameter:
//   RESET_PC  PC loaded on reset, first fetch address
// Build option:
//   FETCH_ALIGN_CHECK_EN  when defined, a redirect to a non-word-aligned
//   target delivers a single if_adel-flagged slot and halts fetching until
//   the next redirect; when undefined, br_target[1:0] is ignored.
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic        clk,
  input logic        rst,
  if_fetch_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,   // first cycle after reset release
    S_FETCH,  // request outstanding for pc
    S_HOLD,   // word parked in the hold buffer, waiting for a free slot
    S_FLUSH,  // waiting out a wrong-path request, its data is discarded
    S_HALT    // misaligned redirect delivered, no fetching until redirect
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic        halt_q, halt_d;     // FLUSH must end in HALT, not FETCH
  logic        adel_q, adel_d;

  logic        slot_free;
  logic        misaligned;
  logic [31:0] target;

`ifdef FETCH_ALIGN_CHECK_EN
  assign target     = bus.br_target;
  assign misaligned = bus.br_target[1:0] != 2'b00;
`else
  logic unused_br_lsb;
  assign target        = {bus.br_target[31:2], 2'b00};
  assign misaligned    = 1'b0;
  assign unused_br_lsb = ^bus.br_target[1:0];
`endif

  always_comb begin
    // NOTE: every _d gets a default first, so no path through the case
    // statements can leave a signal unassigned and infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    out_valid_d = out_valid_q;
    hold_pc_d   = hold_pc_q;
    hold_inst_d = hold_inst_q;
    halt_d      = halt_q;
    adel_d      = adel_q;

    slot_free = !out_valid_q || !bus.stall;

    // A free slot means the current output is consumed (or was empty);
    // whatever loads below overrides this.
    if (slot_free) begin
      out_valid_d = 1'b0;
      adel_d      = 1'b0;
    end

    if (bus.br_flag) begin
      // Redirect wins over stall and ack; everything held here is wrong-path.
      pc_d        = target;
      out_valid_d = 1'b0;
      adel_d      = 1'b0;
      halt_d      = misaligned;
      if (misaligned) begin
        out_pc_d    = target;
        out_inst_d  = 32'h0;
        out_valid_d = 1'b1;
        adel_d      = 1'b1;
      end
      // An unacked request must still complete before the address may move.
      if (req_q && !bus.imem_ack) state_d = S_FLUSH;
      else if (misaligned)        state_d = S_HALT;
      else                        state_d = S_FETCH;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_FETCH;
        S_FETCH: begin
          if (bus.imem_ack) begin
            pc_d = pc_q + 32'd4;
            if (slot_free) begin
              out_pc_d    = pc_q;
              out_inst_d  = bus.imem_rdata;
              out_valid_d = 1'b1;
            end else begin
              hold_pc_d   = pc_q;
              hold_inst_d = bus.imem_rdata;
              state_d     = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (slot_free) begin
            out_pc_d    = hold_pc_q;
            out_inst_d  = hold_inst_q;
            out_valid_d = 1'b1;
            state_d     = S_FETCH;
          end
        end
        S_FLUSH: begin
          if (bus.imem_ack) state_d = halt_q ? S_HALT : S_FETCH;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end

    // Request/address are registered from the next state so they are clean
    // flop outputs; FLUSH keeps presenting the stale address until its ack.
    req_d  = (state_d == S_FETCH) || (state_d == S_FLUSH);
    addr_d = (state_d == S_FETCH) ? pc_d : addr_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of the others regardless of evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      addr_q      <= RESET_PC;
      out_pc_q    <= 32'h0;
      out_inst_q  <= 32'h0;
      out_valid_q <= 1'b0;
      hold_pc_q   <= 32'h0;
      hold_inst_q <= 32'h0;
      halt_q      <= 1'b0;
      adel_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      out_valid_q <= out_valid_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
      halt_q      <= halt_d;
      adel_q      <= adel_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.if_pc     = out_pc_q;
  assign bus.if_inst   = out_inst_q;
  assign bus.if_valid  = out_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.if_adel   = adel_q;
`else
  logic unused_adel;
  assign unused_adel = adel_q;
`endif

endmodule
